// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   state_e      : controller FSM states
//   op_e         : operation selector latched on a start pulse
//   DefaultWidth : default operand/result width
//   IntMin       : most negative two's-complement value at the default width
package multdiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [DefaultWidth-1:0] IntMin = {1'b1, {(DefaultWidth-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDiv,
    StFix,
    StDone
  } state_e;

  typedef enum logic {
    OpMult = 1'b0,
    OpDiv  = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Magnitude datapath for the iterative multiply/divide unit.
// Holds the 2*WIDTH+1 bit accumulator, the multiplicand/divisor magnitude register,
// the adder/subtractor and the final sign fix-up.
//   clock, reset       : clock and synchronous active-high reset
//   load               : capture |A|, |B| and the result sign; clear the accumulator
//   step               : one shift-add (multiply) or restoring-divide iteration
//   fix                : fold the sign fix-up back into the accumulator
//   op                 : operation for load/step/product selection
//   operandA, operandB : raw two's-complement operands (used on load only)
//   product            : signed result; low WIDTH bits are the product or the quotient
module multdiv_datapath
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  op_e                op,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned AccW = 2 * WIDTH + 1;

  // Multiply: {partial product high (WIDTH+1), multiplier/low product (WIDTH)}.
  // Divide:   {remainder (WIDTH+1), quotient (WIDTH)}.
  logic [AccW-1:0]    accQ, accD;
  logic [WIDTH:0]     mcandQ, mcandD;
  logic               negQ, negD;

  logic [WIDTH:0]     absA, absB;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH+1:0]   diff;
  logic [AccW-1:0]    multNext;
  logic [AccW-1:0]    divShift;
  logic [2*WIDTH-1:0] mag;

  // One extra bit so |most negative value| does not wrap.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? (~ext + 1'b1) : ext;
  endfunction

  always_comb begin
    absA = magnitude(operandA);
    absB = magnitude(operandB);

    // Add multiplicand to the upper half when the multiplier LSB is set; the
    // concatenation below is the sum already shifted right by one.
    sum      = {1'b0, accQ[AccW-1:WIDTH]} + {1'b0, (accQ[0] ? mcandQ : '0)};
    multNext = {sum, accQ[WIDTH-1:1]};

    // Restoring divide: shift the pair, trial-subtract the divisor.
    divShift = {accQ[AccW-2:0], 1'b0};
    diff     = {1'b0, divShift[AccW-1:WIDTH]} - {1'b0, mcandQ};

    mag     = (op == OpMult) ? accQ[2*WIDTH-1:0] : {{WIDTH{1'b0}}, accQ[WIDTH-1:0]};
    product = negQ ? (~mag + 1'b1) : mag;

    accD   = accQ;
    mcandD = mcandQ;
    negD   = negQ;
    if (load) begin
      mcandD = (op == OpMult) ? absA : absB;
      accD   = {{(WIDTH + 1){1'b0}}, ((op == OpMult) ? absB[WIDTH-1:0] : absA[WIDTH-1:0])};
      negD   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
    end else if (step) begin
      if (op == OpMult) begin
        accD = multNext;
      end else if (diff[WIDTH+1]) begin
        accD = divShift;
      end else begin
        accD = {diff[WIDTH:0], divShift[WIDTH-1:1], 1'b1};
      end
    end else if (fix) begin
      // Store the signed value and drop the sign flag so product stays stable.
      accD = {1'b0, product};
      negD = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      accQ   <= '0;
      mcandQ <= '0;
      negQ   <= 1'b0;
    end else begin
      accQ   <= accD;
      mcandQ <= mcandD;
      negQ   <= negD;
    end
  end

endmodule

// File: rtl/multdiv_controller.sv
// Iterative signed multiply/divide unit for the execute stage.
// Runs WIDTH iterations, a sign fix-up cycle and a completion cycle; busy stalls the
// pipeline until the one-cycle data_resultRDY pulse. A new start in any state restarts.
//   clock, reset                 : clock and synchronous active-high reset
//   ctrl_MULT, ctrl_DIV          : one-cycle start pulses (MULT wins if both)
//   data_operandA, data_operandB : operands, sampled on the start edge only
//   data_result                  : product low word or quotient, held until next result
//   data_exception               : overflow / divide-by-zero, held with data_result
//   data_resultRDY               : one-cycle completion pulse
//   busy                         : high from the cycle after a start through the RDY cycle
module multdiv_controller
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             stateQ;
  logic [CNT_W-1:0]   cntQ;
  op_e                opQ;
  logic               divExcQ;

  logic               start;
  op_e                startOp;
  op_e                dpOp;
  logic               divExcD;
  logic               dpStep;
  logic               dpFix;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     prodHigh;
  logic               multOvf;

  always_comb begin
    start   = ctrl_MULT | ctrl_DIV;
    startOp = ctrl_MULT ? OpMult : OpDiv;
    dpOp    = start ? startOp : opQ;
    // Special-case divides are flagged up front; the iterations still run so the
    // latency is the same for every operation.
    divExcD = (data_operandB == '0) ||
              ((data_operandA == MinVal) && (data_operandB == '1));
    dpStep  = !start && ((stateQ == StMult) || (stateQ == StDiv));
    dpFix   = !start && (stateQ == StFix);
    // The low word is representable only if the upper half is a sign extension of it.
    prodHigh = product[2*WIDTH-1:WIDTH-1];
    multOvf  = !((prodHigh == '0) || (prodHigh == '1));
  end

  multdiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     (start),
    .step     (dpStep),
    .fix      (dpFix),
    .op       (dpOp),
    .operandA (data_operandA),
    .operandB (data_operandB),
    .product  (product)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ         <= StIdle;
      cntQ           <= '0;
      opQ            <= OpMult;
      divExcQ        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      stateQ         <= (startOp == OpMult) ? StMult : StDiv;
      cntQ           <= '0;
      opQ            <= startOp;
      divExcQ        <= (startOp == OpDiv) && divExcD;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (stateQ)
        StMult, StDiv: begin
          // Counter holds at its last value; only a start clears it.
          if (cntQ == LastCnt) begin
            stateQ <= StFix;
          end else begin
            cntQ <= cntQ + 1'b1;
          end
        end
        StFix: begin
          data_result    <= divExcQ ? '0 : product[WIDTH-1:0];
          data_exception <= (opQ == OpMult) ? multOvf : divExcQ;
          stateQ         <= StDone;
        end
        StDone: begin
          data_resultRDY <= 1'b1;
          stateQ         <= StIdle;
        end
        StIdle: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed, table-driven bench for multdiv_controller with hand-computed expectations,
// plus sequences for abort/restart, simultaneous starts and mid-operation reset.
module tb_multdiv_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int applied;
  int miscompares;

  always #5 clock = ~clock;

  multdiv_controller #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    bit          isDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a start pulse so the start edge is the next rising edge; returns #1 after it.
  task automatic startOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Count edges after the start edge until RDY is seen; bounded at 100.
  task automatic waitRdy(output int lat, output int busyLow);
    lat     = 0;
    busyLow = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
      if (!busy) busyLow++;
    end while (!data_resultRDY && lat < 100);
  endtask

  task automatic finishOp(input string tag, input logic [31:0] expRes, input logic expExc);
    int lat;
    int busyLow;
    waitRdy(lat, busyLow);
    check({tag, " latency"}, 32'(lat), 32'd34);
    check({tag, " busy dropped"}, 32'(busyLow), 32'd0);
    check({tag, " result"}, data_result, expRes);
    check({tag, " exception"}, {31'd0, data_exception}, {31'd0, expExc});
    @(posedge clock);
    #1;
    check({tag, " rdy width"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic expExc, input string tag);
    startOp(m, d, a, b);
    check({tag, " busy at start"}, {31'd0, busy}, 32'd1);
    check({tag, " rdy at start"}, {31'd0, data_resultRDY}, 32'd0);
    finishOp(tag, expRes, expExc);
  endtask

  initial begin
    applied       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul 7*-3"};
    vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul 2^16*2^16"};
    vecs[2]  = '{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "mul min*1"};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div -7/2"};
    vecs[4]  = '{1'b1, 32'd100,       32'd7,         32'd14,        1'b0, "div 100/7"};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,         32'd0,         1'b1, "div 5/0"};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "div min/-1"};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0, "mul -5*-6"};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "div min/1"};
    vecs[9]  = '{1'b1, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, "div 7/-7"};
    vecs[10] = '{1'b0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, "mul max*2"};

    repeat (2) @(posedge clock);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      runOp(!vecs[i].isDiv, vecs[i].isDiv, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc,
            vecs[i].name);
    end

    // Restart: a divide issued at E0+10 of a multiply; only the divide completes.
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    startOp(1'b0, 1'b1, 32'd20, 32'd5);
    finishOp("abort restart", 32'd4, 1'b0);

    // Both start pulses together: the multiply wins (6*3=18, not 6/3=2).
    runOp(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, "mult wins");

    // Reset at E0+15 of a multiply clears everything; the next multiply works.
    startOp(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    runOp(1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
